// File: rtl/decode_imm_stage.sv
// RV32I decode stage: CUOp + raw 20-bit immediate, buffered in a DEPTH-entry skid FIFO; 1-cycle accept-to-out latency.
// Backpressure: in_ready is (count < DEPTH) from registered state only. Optional macro: DECODE_PERF_CNT_EN.
module decode_imm_stage #(
    parameter int DEPTH  = 2,
    parameter int CUOP_W = 6,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_instr,
    input  logic [XLEN-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CUOP_W-1:0] out_cuop,
    output logic [19:0]       out_imm,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [4:0]        out_rd,
    output logic [XLEN-1:0]   out_pc,
    output logic              out_illegal,
    output logic [31:0]       instr_count,
    output logic [31:0]       stall_count
);

    // CUOp codes shared with the CPU types package; 0 is never produced by decode.
    localparam logic [CUOP_W-1:0] CU_LUI   = CUOP_W'(1),  CU_AUIPC = CUOP_W'(2),
                                  CU_JAL   = CUOP_W'(3),  CU_JALR  = CUOP_W'(4),
                                  CU_BEQ   = CUOP_W'(5),  CU_BNE   = CUOP_W'(6),
                                  CU_BLT   = CUOP_W'(7),  CU_BGE   = CUOP_W'(8),
                                  CU_BLTU  = CUOP_W'(9),  CU_BGEU  = CUOP_W'(10),
                                  CU_LB    = CUOP_W'(11), CU_LH    = CUOP_W'(12),
                                  CU_LW    = CUOP_W'(13), CU_LBU   = CUOP_W'(14),
                                  CU_LHU   = CUOP_W'(15), CU_SB    = CUOP_W'(16),
                                  CU_SH    = CUOP_W'(17), CU_SW    = CUOP_W'(18),
                                  CU_ADDI  = CUOP_W'(19), CU_SLTI  = CUOP_W'(20),
                                  CU_SLTIU = CUOP_W'(21), CU_XORI  = CUOP_W'(22),
                                  CU_ORI   = CUOP_W'(23), CU_ANDI  = CUOP_W'(24),
                                  CU_SLLI  = CUOP_W'(25), CU_SRLI  = CUOP_W'(26),
                                  CU_SRAI  = CUOP_W'(27), CU_ADD   = CUOP_W'(28),
                                  CU_SUB   = CUOP_W'(29), CU_SLL   = CUOP_W'(30),
                                  CU_SLT   = CUOP_W'(31), CU_SLTU  = CUOP_W'(32),
                                  CU_XOR   = CUOP_W'(33), CU_SRL   = CUOP_W'(34),
                                  CU_SRA   = CUOP_W'(35), CU_OR    = CUOP_W'(36),
                                  CU_AND   = CUOP_W'(37), CU_ERROR = CUOP_W'(63);

    localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6F, OP_JALR = 7'h67,
                           OP_BRANCH = 7'h63, OP_LOAD = 7'h03, OP_STORE = 7'h23,
                           OP_IMM = 7'h13, OP_REG = 7'h33;

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [CUOP_W-1:0] cuop;
        logic [19:0]       imm;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [XLEN-1:0]   pc;
        logic              illegal;
    } entry_t;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [19:0]       imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [CUOP_W-1:0] raw_cuop;
    logic [19:0]       raw_imm;
    logic              dec_illegal;
    entry_t            dec_entry;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign imm_i  = {8'b0, in_instr[31:20]};
    assign imm_s  = {8'b0, in_instr[31:25], in_instr[11:7]};
    assign imm_b  = {8'b0, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8]};
    assign imm_u  = in_instr[31:12];
    assign imm_j  = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21]};

    always_comb begin
        raw_cuop = CU_ERROR;
        raw_imm  = '0;
        case (opcode)
            OP_LUI:   begin raw_cuop = CU_LUI;   raw_imm = imm_u; end
            OP_AUIPC: begin raw_cuop = CU_AUIPC; raw_imm = imm_u; end
            OP_JAL:   begin raw_cuop = CU_JAL;   raw_imm = imm_j; end
            OP_JALR: begin
                raw_imm = imm_i;
                if (funct3 == 3'd0) raw_cuop = CU_JALR;
            end
            OP_BRANCH: begin
                raw_imm = imm_b;
                case (funct3)
                    3'd0: raw_cuop = CU_BEQ;
                    3'd1: raw_cuop = CU_BNE;
                    3'd4: raw_cuop = CU_BLT;
                    3'd5: raw_cuop = CU_BGE;
                    3'd6: raw_cuop = CU_BLTU;
                    3'd7: raw_cuop = CU_BGEU;
                    default: ;
                endcase
            end
            OP_LOAD: begin
                raw_imm = imm_i;
                case (funct3)
                    3'd0: raw_cuop = CU_LB;
                    3'd1: raw_cuop = CU_LH;
                    3'd2: raw_cuop = CU_LW;
                    3'd4: raw_cuop = CU_LBU;
                    3'd5: raw_cuop = CU_LHU;
                    default: ;
                endcase
            end
            OP_STORE: begin
                raw_imm = imm_s;
                case (funct3)
                    3'd0: raw_cuop = CU_SB;
                    3'd1: raw_cuop = CU_SH;
                    3'd2: raw_cuop = CU_SW;
                    default: ;
                endcase
            end
            OP_IMM: begin
                raw_imm = imm_i;
                case (funct3)
                    3'd0: raw_cuop = CU_ADDI;
                    3'd2: raw_cuop = CU_SLTI;
                    3'd3: raw_cuop = CU_SLTIU;
                    3'd4: raw_cuop = CU_XORI;
                    3'd6: raw_cuop = CU_ORI;
                    3'd7: raw_cuop = CU_ANDI;
                    3'd1: if (funct7 == 7'h00) raw_cuop = CU_SLLI;
                    3'd5: begin
                        if (funct7 == 7'h00)      raw_cuop = CU_SRLI;
                        else if (funct7 == 7'h20) raw_cuop = CU_SRAI;
                    end
                    default: ;
                endcase
            end
            OP_REG: begin
                case ({funct7, funct3})
                    {7'h00, 3'd0}: raw_cuop = CU_ADD;
                    {7'h20, 3'd0}: raw_cuop = CU_SUB;
                    {7'h00, 3'd1}: raw_cuop = CU_SLL;
                    {7'h00, 3'd2}: raw_cuop = CU_SLT;
                    {7'h00, 3'd3}: raw_cuop = CU_SLTU;
                    {7'h00, 3'd4}: raw_cuop = CU_XOR;
                    {7'h00, 3'd5}: raw_cuop = CU_SRL;
                    {7'h20, 3'd5}: raw_cuop = CU_SRA;
                    {7'h00, 3'd6}: raw_cuop = CU_OR;
                    {7'h00, 3'd7}: raw_cuop = CU_AND;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Illegal encodings still flow downstream, but with a zeroed immediate.
    assign dec_illegal       = (raw_cuop == CU_ERROR);
    assign dec_entry.cuop    = raw_cuop;
    assign dec_entry.imm     = dec_illegal ? 20'd0 : raw_imm;
    assign dec_entry.rs1     = in_instr[19:15];
    assign dec_entry.rs2     = in_instr[24:20];
    assign dec_entry.rd      = in_instr[11:7];
    assign dec_entry.pc      = in_pc;
    assign dec_entry.illegal = dec_illegal;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop;
    entry_t        head;

    assign in_ready  = (count < (AW+1)'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= dec_entry;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW+1)'(1);
            else if (!push && pop) count <= count - (AW+1)'(1);
        end
    end

    assign head        = mem[rd_ptr];
    assign out_cuop    = head.cuop;
    assign out_imm     = head.imm;
    assign out_rs1     = head.rs1;
    assign out_rs2     = head.rs2;
    assign out_rd      = head.rd;
    assign out_pc      = head.pc;
    assign out_illegal = head.illegal;

`ifdef DECODE_PERF_CNT_EN
    // Counters survive flush on purpose: they measure the front end, not pipeline contents.
    logic [31:0] instr_cnt_q, stall_cnt_q;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            instr_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (push)                    instr_cnt_q <= instr_cnt_q + 32'd1;
            if (out_valid && !out_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign instr_count = instr_cnt_q;
    assign stall_count = stall_cnt_q;
`else
    assign instr_count = '0;
    assign stall_count = '0;
`endif

endmodule
